// File: rtl/range_to_platform.sv
// range_to_platform
//   Conditions raw VL53L0X millimetre range samples into a platform position
//   for the game engine. An accepted sample has the sensor offset removed
//   with a floor at zero. It is then averaged over a power-of-two window,
//   scaled, clamped and registered. A valid strobe fires exactly three cycles
//   after the accepted input strobe. A watchdog raises stale when no accepted
//   sample has arrived for TIMEOUT_CYCLES cycles, and it re-arms the window.
//
// Ports
//   clk_i              system clock
//   rst_ni             asynchronous active-low reset
//   range_i[15:0]      raw range from the I2C driver, mm
//   range_valid_i      one-cycle strobe, range_i holds a new sample
//   error_i            driver error level; strobes are ignored while high
//   position_o[9:0]    filtered platform position
//   position_valid_o   one-cycle strobe when position_o updates
//   max_platform_pos_o high while position_o == POS_MAX
//   stale_o            no accepted sample within TIMEOUT_CYCLES, or none yet
module range_to_platform #(
  parameter int DATA_W         = 16,
  parameter int RANGE_OFFSET   = 45,
  parameter int POS_SHIFT      = 1,
  parameter int AVG_LOG2       = 2,
  parameter int POS_MAX        = 400,
  parameter int RANGE_LIMIT    = 8190,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] range_i,
  input  logic              range_valid_i,
  input  logic              error_i,
  output logic [9:0]        position_o,
  output logic              position_valid_o,
  output logic              max_platform_pos_o,
  output logic              stale_o
);

  localparam int WIN   = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  // Offset removal, saturating at zero.
  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] r);
    if (r > DATA_W'(RANGE_OFFSET)) begin
      return r - DATA_W'(RANGE_OFFSET);
    end
    return '0;
  endfunction

  // Upper clamp. The compare uses the full width so that large values are
  // not wrapped into the 10-bit range before they are compared.
  function automatic logic [9:0] clamp_pos(input logic [DATA_W-1:0] p);
    if (p > DATA_W'(POS_MAX)) begin
      return 10'(POS_MAX);
    end
    return p[9:0];
  endfunction

  logic accept;
  assign accept = range_valid_i & ~error_i & (range_i < DATA_W'(RANGE_LIMIT));

  // ---- stage p1: offset removal, watchdog ----
  logic [DATA_W-1:0] sub_p1_q;
  logic              vld_p1_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stale_q, stale_d;
  logic              timeout_hit;

  always_comb begin
    cnt_d       = cnt_q;
    stale_d     = stale_q;
    timeout_hit = 1'b0;
    if (accept) begin
      // A sample that arrives on the timeout cycle wins.
      cnt_d   = '0;
      stale_d = 1'b0;
    end else if (cnt_q != TIMEOUT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == TIMEOUT) begin
        stale_d     = 1'b1;
        timeout_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1_q <= 1'b0;
      cnt_q    <= '0;
      stale_q  <= 1'b1;
    end else begin
      vld_p1_q <= accept;
      cnt_q    <= cnt_d;
      stale_q  <= stale_d;
    end
  end

  // Pure data register. It is only consumed when vld_p1_q is set.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      sub_p1_q <= sat_sub(range_i);
    end
  end

  // ---- stage p2: moving-average window ----
  logic [DATA_W-1:0]   win_q [WIN];
  logic [DATA_W-1:0]   win_d [WIN];
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                primed_q, primed_d;
  logic                vld_p2_q;

  always_comb begin
    win_d    = win_q;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    primed_d = primed_q;
    // The watchdog drops the history so the next sample re-primes the window.
    if (timeout_hit) begin
      primed_d = 1'b0;
    end
    if (vld_p1_q) begin
      if (!primed_q) begin
        // First sample fills the whole window, so there is no ramp from zero.
        for (int i = 0; i < WIN; i++) begin
          win_d[i] = sub_p1_q;
        end
        sum_d    = SUM_W'(sub_p1_q) << AVG_LOG2;
        wr_ptr_d = '0;
        primed_d = 1'b1;
      end else begin
        win_d[wr_ptr_q] = sub_p1_q;
        sum_d    = sum_q - SUM_W'(win_q[wr_ptr_q]) + SUM_W'(sub_p1_q);
        wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= '0;
      end
      sum_q    <= '0;
      wr_ptr_q <= '0;
      primed_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      sum_q    <= sum_d;
      wr_ptr_q <= wr_ptr_d;
      primed_q <= primed_d;
      vld_p2_q <= vld_p1_q;
    end
  end

  // ---- stage p3: scale, clamp, register outputs ----
  logic [DATA_W-1:0] avg_p3;
  logic [DATA_W-1:0] scaled_p3;
  logic [9:0]        pos_p3;
  logic [9:0]        pos_q;
  logic              vld_p3_q;
  logic              max_q;

  assign avg_p3    = DATA_W'(sum_q >> AVG_LOG2);
  assign scaled_p3 = avg_p3 >> POS_SHIFT;
  assign pos_p3    = clamp_pos(scaled_p3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q    <= '0;
      max_q    <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        pos_q <= pos_p3;
        max_q <= (pos_p3 == 10'(POS_MAX));
      end
    end
  end

  assign position_o         = pos_q;
  assign position_valid_o   = vld_p3_q;
  assign max_platform_pos_o = max_q;
  assign stale_o            = stale_q;

endmodule

// File: tb/tb_range_to_platform.sv
module tb_range_to_platform;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] range_in = '0;
  logic        range_valid = 1'b0;
  logic        error_in = 1'b0;
  logic [9:0]  position;
  logic        position_valid;
  logic        max_pos;
  logic        stale;

  range_to_platform #(
    .DATA_W(16), .RANGE_OFFSET(45), .POS_SHIFT(1), .AVG_LOG2(2),
    .POS_MAX(400), .RANGE_LIMIT(8190), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .range_i(range_in),
    .range_valid_i(range_valid),
    .error_i(error_in),
    .position_o(position),
    .position_valid_o(position_valid),
    .max_platform_pos_o(max_pos),
    .stale_o(stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] pos;
    logic       mx;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every position_valid pulse must match the oldest expectation,
  // both in value and in the cycle it arrives.
  always @(negedge clk) begin
    if (rst_n && position_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got pos=%0d max=%0d at cycle %0d, required no valid", position, max_pos, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (position !== e.pos || max_pos !== e.mx || cyc != e.due) begin
          errors++;
          $display("FAIL position_out: got pos=%0d max=%0d cycle=%0d, required pos=%0d max=%0d cycle=%0d",
                   position, max_pos, cyc, e.pos, e.mx, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Called at a negedge. It drives one cycle of inputs and returns at the next negedge.
  task automatic drive(input int r, input bit v, input bit e);
    range_in    = 16'(r);
    range_valid = v;
    error_in    = e;
    @(negedge clk);
    range_valid = 1'b0;
    error_in    = 1'b0;
  endtask

  task automatic sample(input int r, input int pos, input bit mx);
    exp_t e;
    e.pos = 10'(pos);
    e.mx  = mx;
    e.due = cyc + 3;
    exp_q.push_back(e);
    drive(r, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("reset_position", position, 0);
    check("reset_valid", position_valid, 0);
    check("reset_max", max_pos, 0);
    check("reset_stale", stale, 1);

    // 2: single strobe, latency 3
    sample(245, 100, 0);
    check("stale_clear_n1", stale, 0);
    idle(4);

    // 3: blend on the primed window
    sample(445, 125, 0);
    sample(445, 150, 0);
    sample(445, 175, 0);
    sample(445, 200, 0);
    // counter is 0 here
    idle(4);
    // 5: rejected strobes
    drive(8190, 1'b1, 1'b0);
    drive(245, 1'b1, 1'b1);
    idle(4);
    check("reject_position", position, 200);
    check("reject_stale", stale, 0);
    // total idle since last accept is now 10; stale must rise exactly at 1000
    idle(989);
    check("stale_before_timeout", stale, 0);
    idle(1);
    check("stale_at_timeout", stale, 1);
    check("position_held_stale", position, 200);

    // 6: re-prime after timeout
    sample(245, 100, 0);
    idle(4);
    // 45-mm floor: window 4x200 -> sum 600 -> 75
    sample(45, 75, 0);
    idle(4);

    // 4: clamp and descend
    do_reset();
    sample(1000, 400, 1);
    idle(4);
    check("max_flag_set", max_pos, 1);
    sample(30, 358, 0);
    sample(30, 238, 0);
    sample(30, 119, 0);
    sample(30, 0, 0);
    idle(4);
    check("final_position", position, 0);
    check("max_flag_clear", max_pos, 0);

    // reset mid-pipeline discards the in-flight sample
    drive(245, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_position", position, 0);
    check("midrst_valid", position_valid, 0);
    check("midrst_max", max_pos, 0);
    check("midrst_stale", stale, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check("post_midrst_position", position, 0);
    check("post_midrst_stale", stale, 1);

    check("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/range_to_platform.md
Name: range_to_platform

Overview:
- Conditioning stage between the VL53L0X I2C driver and the game engine.
- Takes raw millimetre range samples and rejects invalid or out-of-range readings.
- Removes the sensor offset, smooths samples with a power-of-two moving average, scales and clamps the result, then registers the platform position with a valid strobe.
- Drives the max-position flag and a stale flag that is set when the sensor stops delivering samples.

Parameters:
RANGE_OFFSET, 45, mm subtracted from each raw sample; result saturates at 0
POS_SHIFT, 1, averaged value is right-shifted by this amount (divide by 2^POS_SHIFT)
AVG_LOG2, 2, moving-average window of 2^AVG_LOG2 samples
POS_MAX, 400, upper clamp for position (10-bit value)
RANGE_LIMIT, 8190, raw samples >= this are rejected (sensor out-of-range code)
TIMEOUT_CYCLES, 4000000, clk cycles without an accepted sample before stale asserts

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
range  in  16  raw range from I2C driver, mm
range_valid  in  1  one-cycle strobe: range holds a new sample
error  in  1  driver error level; range_valid is ignored while high
position  out  10  filtered platform position
position_valid  out  1  one-cycle strobe when position updates
max_platform_pos  out  1  high while position == POS_MAX
stale  out  1  no accepted sample within TIMEOUT_CYCLES, or none since reset

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - position=0, position_valid=0, max_platform_pos=0, stale=1;
  - primed=0, window buffer and sum=0, timeout counter=0;
  - all pipeline valid bits=0.
- Accept condition: range_valid & ~error & (range < RANGE_LIMIT). Rejected strobes have no effect on any state or output and do not clear the timeout counter.
- Stage 1 (cycle N+1, N = cycle of accepted strobe):
  - sub = (range > RANGE_OFFSET) ? range - RANGE_OFFSET : 0, 16 bits.
  - Timeout counter clears and stale deasserts.
- Stage 2 (N+2), window update:
  - If primed=0: all 2^AVG_LOG2 entries are written with sub, sum = sub << AVG_LOG2, primed is set.
  - Otherwise: the oldest entry is replaced by sub, sum = sum - oldest + sub, and the write pointer advances modulo 2^AVG_LOG2.
  - sum is 16+AVG_LOG2 bits wide and never overflows.
- Stage 3 (N+3), output:
  - avg = sum >> AVG_LOG2; p = avg >> POS_SHIFT, compared at full width.
  - position = (p > POS_MAX) ? POS_MAX : p[9:0].
  - position_valid high for exactly this one cycle.
  - max_platform_pos = (new position == POS_MAX), registered alongside position.
- Latency is fixed at 3 cycles from strobe to position_valid. The pipeline accepts back-to-back strobes, one per cycle, with throughput 1.
- position holds its value between updates and while stale.
- Timeout counter:
  - Increments every cycle while no accepted sample arrives; saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: stale=1 and primed=0, so the next accepted sample re-primes the window.
  - If an accepted sample arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the sample wins: counter clears and stale stays 0.
- error high mid-pipeline does not cancel samples already accepted.
- Reset asserted mid-pipeline discards in-flight samples; no position_valid is produced for them.

Test Plan:
1. Release reset, no stimulus for 10 cycles -> position=0, position_valid=0, max_platform_pos=0, stale=1.
2. Single strobe range=245 at cycle N -> stale=0 at N+1; position=100 with position_valid pulse at N+3 only.
3. Prime with 245, then 445 three times back-to-back -> positions 125, 150, 175 on consecutive cycles; a fourth 445 -> 200.
4. Boundaries:
   - Fresh reset, range=1000 -> position=400, max_platform_pos=1.
   - Then range=30 repeated four times -> position decreases, final value 0, max_platform_pos=0.
   - 45-mm floor: range=45 gives sub=0.
5. Rejection:
   - range=8190 strobe -> no position_valid, position unchanged.
   - Strobe with error=1 -> same result.
   - Neither strobe resets the timeout counter (TIMEOUT_CYCLES=1000 in bench).
6. Timeout and reset:
   - TIMEOUT_CYCLES=1000: after position=200, idle 1000 cycles -> stale=1.
   - Next range=245 -> position=100 directly (re-primed, no blend).
   - Async reset pulsed at N+1 after a strobe -> no position_valid, outputs at reset values.
